// File: rtl/alu_arbiter_if.sv
// Requester-side channels of the shared ALU arbiter: valid/ready request and
// response buses, packed per requester.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_ofl;
  logic                      rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ofl, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ofl, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Operands are registered ahead of the ALU and the result is registered after it.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_arbiter_if.slave       req_if,
  output logic [OP_W-1:0]    alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic               alu_ofl,
  input  logic               alu_err,
  output logic               busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    cand_idx;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_vld;
  int                  cand;
  logic [NUM_REQ-1:0]  req_ready_c;
  logic [NUM_REQ-1:0]  rsp_valid_c;

  logic [OP_W-1:0]     op_p0;
  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;
  logic [DATA_W-1:0]   res_p1;
  logic                ofl_p1;
  logic                err_p1;

  // Search upward from the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    state_nxt   = state;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    req_ready_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_vld && req_if.req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready_c[grant_idx] = 1'b1;
          state_nxt              = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP: begin
        if (req_if.rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_c = '0;
    if (state == RESP) rsp_valid_c[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      op_p0  <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      res_p1 <= '0;
      ofl_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      // Stage 0: operands of the granted requester captured at the handshake.
      if (state == IDLE && grant_vld) begin
        owner <= grant_idx;
        op_p0 <= req_if.req_op[grant_idx*OP_W +: OP_W];
        a_p0  <= req_if.req_a[grant_idx*DATA_W +: DATA_W];
        b_p0  <= req_if.req_b[grant_idx*DATA_W +: DATA_W];
      end
      // Stage 1: ALU result captured and held until the owner consumes it.
      if (state == EXEC) begin
        res_p1 <= alu_c;
        ofl_p1 <= alu_ofl;
        err_p1 <= alu_err;
      end
      if (state == RESP && req_if.rsp_ready[owner]) begin
        rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

  assign req_if.req_ready = req_ready_c;
  assign req_if.rsp_valid = rsp_valid_c;
  assign req_if.rsp_data  = res_p1;
  assign req_if.rsp_ofl   = ofl_p1;
  assign req_if.rsp_err   = err_p1;
  assign alu_op           = op_p0;
  assign alu_a            = a_p0;
  assign alu_b            = b_p0;
  assign busy             = (state != IDLE);
endmodule
